// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count, sticky error flags and FIFO_FWFT_EN first-word-fall-through read mode
module sync_fifo_param #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write_en,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     read_en,
  output logic [WIDTH-1:0]         data_out,
  input  logic                     err_clr,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_CNT = (AW+1)'(AE_THRESH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic rd_ok, wr_ok;
  assign empty = count == '0;
  assign full = count == FULL_CNT;
  assign almost_full = count >= AF_CNT;
  assign almost_empty = count <= AE_CNT;
  assign rd_ok = read_en && !empty;
  assign wr_ok = write_en && (!full || rd_ok);
  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr] <= data_in;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      if (wr_ok != rd_ok) count <= wr_ok ? count + (AW+1)'(1) : count - (AW+1)'(1);
      overflow <= (write_en && !wr_ok) || (overflow && !err_clr);
      underflow <= (read_en && !rd_ok) || (underflow && !err_clr);
    end
`ifdef FIFO_FWFT_EN
  assign data_out = mem[rd_ptr];
`else
  always_ff @(posedge clk or negedge reset)
    if (!reset) data_out <= '0;
    else if (rd_ok) data_out <= mem[rd_ptr];
`endif
endmodule
